// File: rtl/imem_responder.sv
// Instruction memory responder: loads a program word-by-word, then serves
// one registered instruction fetch per cycle from the loaded region.
module imem_responder #(
    parameter int          DEPTH         = 256,
    parameter logic [31:0] INS_BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR     = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc,
    output logic [31:0]              instr,
    output logic                     instr_valid,
    output logic                     fetch_err,
    input  logic                     ld_start,
    input  logic                     ld_we,
    input  logic [31:0]              ld_data,
    input  logic                     ld_done,
    output logic                     ld_busy,
    output logic [$clog2(DEPTH):0]   ld_count,
    output logic                     ld_ovf,
    output logic                     run
);

    localparam int              AW   = $clog2(DEPTH);
    localparam int              CW   = AW + 1;
    localparam logic [31:0]     SPAN = 32'(DEPTH) * 32'd4;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   offset;
    logic [AW-1:0] index;
    logic          misaligned;
    logic          fetch_ok;
    logic          do_write;

    // Offset wraps, so a pc below the base lands far above SPAN.
    assign offset     = pc - INS_BASE_ADDR;
    assign index      = offset[AW+1:2];
    assign misaligned = |pc[1:0];
    assign fetch_ok   = !misaligned && (offset < SPAN) && ({1'b0, index} < ld_count);

    assign do_write = !reset && !ld_start && (state == S_LOAD) && ld_we && (ld_count != FULL);

    assign ld_busy = (state == S_LOAD);
    assign run     = (state == S_RUN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is given a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (ld_start) state_next = S_LOAD;
            S_LOAD: begin
                if (ld_start)     state_next = S_LOAD;
                else if (ld_done) state_next = S_RUN;
            end
            S_RUN:  if (ld_start) state_next = S_LOAD;
            default: state_next = S_IDLE;
        endcase
    end

    // ld_start clears the load bookkeeping from any state, winning over ld_done.
    always_ff @(posedge clk) begin
        if (reset || ld_start) begin
            ld_count <= '0;
            ld_ovf   <= 1'b0;
        end else if (state == S_LOAD && ld_we) begin
            if (ld_count == FULL) begin
                ld_ovf <= 1'b1;
            end else begin
                ld_count <= ld_count + 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; ld_count == 0 after reset makes
    // every stale word unreachable, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[ld_count[AW-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else if (state == S_RUN) begin
            if (fetch_ok) begin
                instr       <= mem[index];
                instr_valid <= 1'b1;
                fetch_err   <= 1'b0;
            end else begin
                instr       <= NOP_INSTR;
                instr_valid <= 1'b0;
                fetch_err   <= 1'b1;
            end
        end else begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH, default 256, instruction storage depth in 32-bit words (power of two).
REQ-002 Parameter INS_BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0013, word returned whenever no valid instruction exists.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pc  input  32  byte fetch address from the core.
REQ-007 instr  output  32  fetched instruction word, registered.
REQ-008 instr_valid  output  1  instr holds a stored, in-range instruction.
REQ-009 fetch_err  output  1  fetch was misaligned, out of range, or beyond the loaded region.
REQ-010 ld_start  input  1  one-cycle pulse opening a program load.
REQ-011 ld_we  input  1  write ld_data at the current load pointer.
REQ-012 ld_data  input  32  program word to store.
REQ-013 ld_done  input  1  one-cycle pulse closing the load.
REQ-014 ld_busy  output  1  high while in LOAD.
REQ-015 ld_count  output  $clog2(DEPTH)+1  number of words stored by the last or current load.
REQ-016 ld_ovf  output  1  sticky: write attempted with ld_count == DEPTH.
REQ-017 run  output  1  high while in RUN.

Function
REQ-018 States IDLE, LOAD, RUN, one-hot or encoded; state is fully visible via ld_busy and run.
REQ-019 IDLE: ld_start -> LOAD; all other inputs ignored.
REQ-020 LOAD: ld_done -> RUN; ld_start restarts the load (ld_count <= 0, ld_ovf <= 0), stays LOAD.
REQ-021 RUN: ld_start -> LOAD with ld_count <= 0, ld_ovf <= 0; run drops the following cycle.
REQ-022 ld_start and ld_done in the same cycle: ld_start wins in every state.
REQ-023 Entering LOAD from IDLE or RUN clears ld_count and ld_ovf in the same edge.
REQ-024 LOAD with ld_we and ld_count < DEPTH: mem[ld_count] <= ld_data, ld_count increments.
REQ-025 LOAD with ld_we and ld_count == DEPTH: no write, ld_count holds, ld_ovf <= 1.
REQ-026 ld_we together with ld_done: the write occurs, then RUN; ld_we outside LOAD is ignored.
REQ-027 Fetch offset = pc - INS_BASE_ADDR (32-bit unsigned, wraps); index = offset[31:2].
REQ-028 Fetch latency exactly 1 cycle: instr/instr_valid/fetch_err at edge N+1 reflect pc and state at edge N.
REQ-029 In RUN, pc[1:0] != 0, or offset >= DEPTH*4, or index >= ld_count: instr <= NOP_INSTR, instr_valid <= 0, fetch_err <= 1.
REQ-030 In RUN otherwise: instr <= mem[index], instr_valid <= 1, fetch_err <= 0.
REQ-031 pc below INS_BASE_ADDR wraps to a large offset and is out of range per REQ-029.
REQ-032 In IDLE or LOAD: instr <= NOP_INSTR, instr_valid <= 0, fetch_err <= 0, regardless of pc.
REQ-033 Write and fetch never coincide, since fetch is served only in RUN and writes only in LOAD.
REQ-034 New fetch each cycle; no stall or handshake toward the core.

Reset
REQ-035 reset is sampled on clk and overrides every other input in that cycle.
REQ-036 Reset values: state IDLE, instr NOP_INSTR, instr_valid 0, fetch_err 0, ld_busy 0, run 0, ld_count 0, ld_ovf 0.
REQ-037 Memory contents are not reset; ld_count == 0 makes every stale word unreachable.
REQ-038 Reset mid-LOAD abandons the load; ld_start is required to reload.

Verification
REQ-039 Reset, pc=0 for 5 cycles -> instr=32'h13, instr_valid=0, fetch_err=0, run=0.
REQ-040 ld_start; ld_we with 32'hA, 32'hB, 32'hC; ld_done; pc=4 -> next cycle instr=32'hB, instr_valid=1, ld_count=3, run=1.
REQ-041 After REQ-040 load: pc=12 -> instr=32'h13, fetch_err=1; pc=2 -> fetch_err=1; pc=32'hFFFF_FFFC -> fetch_err=1.
REQ-042 Load DEPTH+2 words -> ld_count=DEPTH, ld_ovf=1, mem[0] unchanged from the first word.
REQ-043 ld_start and ld_done same cycle in RUN -> LOAD, ld_busy=1, ld_count=0, instr=32'h13 next cycle.
REQ-044 Reset asserted mid-LOAD after 2 writes -> IDLE, ld_count=0; then ld_done -> stays IDLE.
